// File: rtl/hermes_pkg.sv
// Shared types for the Hermes router control stage: port indices, FSM states,
// header field layout and the XY routing rule.
package hermes_pkg;

    localparam int NPORT       = 5;
    localparam int PORT_W      = 3;
    localparam int HDR_FIELD_W = 8;
    localparam int HDR_X_LSB   = 8;
    localparam int HDR_Y_LSB   = 0;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        CHECK = 2'd2,
        ACK   = 2'd3
    } ctrl_state_t;

    // X is resolved completely before Y, which keeps XY routing deadlock-free.
    function automatic port_t xy_route(
        input logic [HDR_FIELD_W-1:0] tx,
        input logic [HDR_FIELD_W-1:0] ty,
        input logic [HDR_FIELD_W-1:0] x,
        input logic [HDR_FIELD_W-1:0] y
    );
        port_t p;
        if (tx > x)      p = EAST;
        else if (tx < x) p = WEST;
        else if (ty > y) p = NORTH;
        else if (ty < y) p = SOUTH;
        else             p = LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Round-robin pick of the first requester after ptr_i (ptr_i itself is checked last).
// Purely combinational; no backpressure, the caller samples grant_o when vld_o is set.
module hermes_rr_arbiter
    import hermes_pkg::*;
(
    input  logic [NPORT-1:0]  req_i,
    input  logic [PORT_W-1:0] ptr_i,
    output logic [PORT_W-1:0] grant_o,
    output logic              vld_o
);

    localparam int CW = PORT_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant_o = '0;
        vld_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = {1'b0, ptr_i} + CW'(k);
            if (cand >= CW'(NPORT)) begin
                cand = cand - CW'(NPORT);
            end
            if (!vld_o && req_i[cand[PORT_W-1:0]]) begin
                vld_o   = 1'b1;
                grant_o = cand[PORT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes router control: round-robin request arbitration, XY routing, output allocation.
// Latency: request seen in IDLE -> req_ack_o and out_busy_o three cycles later; busy output retries.
module hermes_switch_control
    import hermes_pkg::*;
#(
    parameter int         FLIT_SIZE = 32,
    parameter logic [7:0] X_ADDR    = 8'd0,
    parameter logic [7:0] Y_ADDR    = 8'd0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NPORT-1:0]                  req_i,
    input  logic [NPORT-1:0]                  sending_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]   header_i,
    output logic [NPORT-1:0]                  req_ack_o,
    output logic [NPORT-1:0]                  out_busy_o,
    output logic [NPORT-1:0][PORT_W-1:0]      out_sel_o,
    output logic [NPORT-1:0][PORT_W-1:0]      in_sel_o
);

    ctrl_state_t                    state_q,    state_d;
    logic [PORT_W-1:0]              sel_q,      sel_d;
    logic [PORT_W-1:0]              ptr_q,      ptr_d;
    port_t                          dest_q,     dest_d;
    logic [NPORT-1:0]               req_ack_q,  req_ack_d;
    logic [NPORT-1:0]               out_busy_q, out_busy_d;
    logic [NPORT-1:0]               active_q,   active_d;
    logic [NPORT-1:0]               sending_q,  sending_d;
    logic [NPORT-1:0][PORT_W-1:0]   out_sel_q,  out_sel_d;
    logic [NPORT-1:0][PORT_W-1:0]   in_sel_q,   in_sel_d;

    logic [PORT_W-1:0]              arb_grant;
    logic                           arb_vld;
    logic [HDR_FIELD_W-1:0]         hdr_tx;
    logic [HDR_FIELD_W-1:0]         hdr_ty;
    logic                           unused_hdr_bits;

    hermes_rr_arbiter u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .vld_o   (arb_vld)
    );

    assign hdr_tx          = header_i[sel_q][HDR_X_LSB +: HDR_FIELD_W];
    assign hdr_ty          = header_i[sel_q][HDR_Y_LSB +: HDR_FIELD_W];
    // Only the X/Y fields steer routing; the rest of the head flit passes untouched.
    assign unused_hdr_bits = ^header_i;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        dest_d     = dest_q;
        req_ack_d  = '0;
        out_busy_d = out_busy_q;
        active_d   = active_q;
        sending_d  = sending_i;
        out_sel_d  = out_sel_q;
        in_sel_d   = in_sel_q;

        // Falling edge of sending ends the packet and frees its output.
        for (int i = 0; i < NPORT; i++) begin
            if (active_q[i] && sending_q[i] && !sending_i[i]) begin
                active_d[i]             = 1'b0;
                out_busy_d[in_sel_q[i]] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    sel_d   = arb_grant;
                    ptr_d   = arb_grant;
                    state_d = ROUTE;
                end
            end
            ROUTE: begin
                dest_d  = xy_route(hdr_tx, hdr_ty, X_ADDR, Y_ADDR);
                state_d = CHECK;
            end
            CHECK: begin
                if (!out_busy_q[dest_q]) begin
                    out_busy_d[dest_q] = 1'b1;
                    out_sel_d[dest_q]  = sel_q;
                    in_sel_d[sel_q]    = dest_q;
                    active_d[sel_q]    = 1'b1;
                    req_ack_d[sel_q]   = 1'b1;
                    state_d            = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= PORT_W'(NPORT - 1);
            dest_q     <= EAST;
            req_ack_q  <= '0;
            out_busy_q <= '0;
            active_q   <= '0;
            sending_q  <= '0;
            out_sel_q  <= '0;
            in_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            dest_q     <= dest_d;
            req_ack_q  <= req_ack_d;
            out_busy_q <= out_busy_d;
            active_q   <= active_d;
            sending_q  <= sending_d;
            out_sel_q  <= out_sel_d;
            in_sel_q   <= in_sel_d;
        end
    end

    assign req_ack_o  = req_ack_q;
    assign out_busy_o = out_busy_q;
    assign out_sel_o  = out_sel_q;
    assign in_sel_o   = in_sel_q;

endmodule
